// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected LIF layer: FSM state encoding
// and the default layer geometry / neuron constants.
package fc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_EMIT = 2'd2
   } fc_state_e;

   localparam int P_TIME_STEPS   = 10;
   localparam int P_EC_SIZE      = 4;
   localparam int P_LAYER_SIZE   = 32;
   localparam int P_FAN_IN       = 240;
   localparam int P_WEIGHT_WIDTH = 8;
   localparam int P_MEM_WIDTH    = 16;
   localparam int P_THRESHOLD    = 64;
   localparam int P_BETA_SHIFT   = 3;

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire lane: saturating weight accumulator plus
// membrane update with shift-based leak, threshold and subtractive reset.
module lif_neuron import fc_pkg::*; #(
   parameter int WEIGHT_WIDTH = P_WEIGHT_WIDTH,
   parameter int MEM_WIDTH    = P_MEM_WIDTH,
   parameter int THRESHOLD    = P_THRESHOLD,
   parameter int BETA_SHIFT   = P_BETA_SHIFT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    add_en,
   input  logic [WEIGHT_WIDTH-1:0] weight,
   input  logic                    fire,
   input  logic                    clear,
   output logic                    spike
);

   localparam int XW = MEM_WIDTH + 2;
   localparam logic signed [XW-1:0] MAX_V = XW'((2 ** (MEM_WIDTH - 1)) - 1);
   localparam logic signed [XW-1:0] MIN_V = XW'(-(2 ** (MEM_WIDTH - 1)));
   localparam logic signed [XW-1:0] THR_X = XW'(THRESHOLD);

   logic signed [MEM_WIDTH-1:0] mem_q, mem_d;
   logic signed [MEM_WIDTH-1:0] acc_q, acc_d;
   logic signed [XW-1:0]        w_x, mem_x, acc_x, acc_base, m_x, m_sat_x;
   logic signed [MEM_WIDTH-1:0] m_sat;
   logic                        over_thr;

   function automatic logic signed [MEM_WIDTH-1:0] sat(input logic signed [XW-1:0] v);
      if (v > MAX_V)      sat = MAX_V[MEM_WIDTH-1:0];
      else if (v < MIN_V) sat = MIN_V[MEM_WIDTH-1:0];
      else                sat = v[MEM_WIDTH-1:0];
   endfunction

   always_comb begin
      w_x      = {{(XW-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};
      mem_x    = {{2{mem_q[MEM_WIDTH-1]}}, mem_q};
      acc_x    = {{2{acc_q[MEM_WIDTH-1]}}, acc_q};
      // A weight arriving in the fire cycle starts the next step's sum.
      acc_base = fire ? '0 : acc_x;
      m_x      = mem_x - (mem_x >>> BETA_SHIFT) + acc_x;
      m_sat    = sat(m_x);
      m_sat_x  = {{2{m_sat[MEM_WIDTH-1]}}, m_sat};
      over_thr = (m_sat_x >= THR_X);
      spike    = fire && over_thr;

      mem_d = mem_q;
      acc_d = acc_q;
      if (fire) begin
         mem_d = over_thr ? MEM_WIDTH'(m_sat_x - THR_X) : m_sat;
         acc_d = '0;
      end
      if (add_en) acc_d = sat(acc_base + w_x);
      if (clear) begin
         mem_d = '0;
         acc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
         acc_q <= '0;
      end else begin
         mem_q <= mem_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/fc_lif_ec.sv
// Fully-connected LIF layer engine for one EC_SIZE-neuron group: weight fetch
// per input spike, lane accumulation, and per-time-step fire/emit sequencing.
module fc_lif_ec import fc_pkg::*; #(
   parameter int TIME_STEPS   = P_TIME_STEPS,
   parameter int EC_SIZE      = P_EC_SIZE,
   parameter int LAYER_SIZE   = P_LAYER_SIZE,
   parameter int FAN_IN       = P_FAN_IN,
   parameter int WEIGHT_WIDTH = P_WEIGHT_WIDTH,
   parameter int MEM_WIDTH    = P_MEM_WIDTH,
   parameter int THRESHOLD    = P_THRESHOLD,
   parameter int BETA_SHIFT   = P_BETA_SHIFT
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          en_accum,
   input  logic [$clog2(FAN_IN):0]                       spk_addr,
   input  logic [$clog2(LAYER_SIZE)+1:0]                 neuron,
   input  logic                                          new_spk_train_ready,
   input  logic                                          last_time_step,
   output logic                                          w_en,
   output logic [$clog2(LAYER_SIZE/EC_SIZE*FAN_IN)-1:0]  w_addr,
   input  logic [EC_SIZE*WEIGHT_WIDTH-1:0]               w_data,
   output logic                                          out_valid,
   output logic [EC_SIZE-1:0]                            out_spk,
   output logic [$clog2(LAYER_SIZE)+1:0]                 out_neuron,
   output logic [$clog2(TIME_STEPS)+1:0]                 out_time_step,
   output logic                                          layer_done,
   output fc_state_e                                     dbg_state
);

   localparam int AW = $clog2(LAYER_SIZE/EC_SIZE*FAN_IN);
   localparam int NW = $clog2(LAYER_SIZE) + 2;
   localparam int SW = $clog2(TIME_STEPS) + 2;

   fc_state_e         state_q, state_d;
   logic              w_en_q, w_en_d, add_q, add_d;
   logic [AW-1:0]     w_addr_q, w_addr_d;
   logic [1:0]        trig_q, trig_d, tlast_q, tlast_d;
   logic              is_last_q, is_last_d;
   logic [SW-1:0]     step_q, step_d;
   logic              out_valid_q, out_valid_d, layer_done_q, layer_done_d;
   logic [EC_SIZE-1:0] out_spk_q, out_spk_d, lane_spk;
   logic [NW-1:0]     out_neuron_q, out_neuron_d;
   logic [SW-1:0]     out_step_q, out_step_d;
   logic              fire, clear;

   always_comb begin
      state_d      = state_q;
      w_en_d       = en_accum;
      w_addr_d     = w_addr_q;
      add_d        = w_en_q;
      // Two trigger flops plus the IDLE->FIRE edge give the 3-cycle delay
      // that lets every earlier weight land in acc first.
      trig_d       = {trig_q[0], new_spk_train_ready};
      tlast_d      = {tlast_q[0], new_spk_train_ready & last_time_step};
      is_last_d    = is_last_q;
      step_d       = step_q;
      out_valid_d  = 1'b0;
      layer_done_d = 1'b0;
      out_spk_d    = out_spk_q;
      out_neuron_d = out_neuron_q;
      out_step_d   = out_step_q;
      fire         = 1'b0;
      clear        = 1'b0;

      if (en_accum)
         w_addr_d = AW'((int'(neuron) / EC_SIZE) * FAN_IN + int'(spk_addr));

      case (state_q)
         ST_IDLE: begin
            if (trig_q[1]) begin
               state_d   = ST_FIRE;
               is_last_d = tlast_q[1];
            end
         end
         ST_FIRE: begin
            fire         = 1'b1;
            state_d      = ST_EMIT;
            out_valid_d  = 1'b1;
            out_spk_d    = lane_spk;
            out_neuron_d = neuron;
            out_step_d   = step_q;
            layer_done_d = is_last_q && (neuron == NW'(LAYER_SIZE - EC_SIZE));
         end
         ST_EMIT: begin
            state_d = ST_IDLE;
            if (is_last_q) begin
               clear  = 1'b1;
               step_d = '0;
            end else begin
               step_d = (step_q == SW'(TIME_STEPS - 1)) ? '0 : step_q + SW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         w_en_q       <= 1'b0;
         w_addr_q     <= '0;
         add_q        <= 1'b0;
         trig_q       <= '0;
         tlast_q      <= '0;
         is_last_q    <= 1'b0;
         step_q       <= '0;
         out_valid_q  <= 1'b0;
         layer_done_q <= 1'b0;
         out_spk_q    <= '0;
         out_neuron_q <= '0;
         out_step_q   <= '0;
      end else begin
         state_q      <= state_d;
         w_en_q       <= w_en_d;
         w_addr_q     <= w_addr_d;
         add_q        <= add_d;
         trig_q       <= trig_d;
         tlast_q      <= tlast_d;
         is_last_q    <= is_last_d;
         step_q       <= step_d;
         out_valid_q  <= out_valid_d;
         layer_done_q <= layer_done_d;
         out_spk_q    <= out_spk_d;
         out_neuron_q <= out_neuron_d;
         out_step_q   <= out_step_d;
      end
   end

   for (genvar i = 0; i < EC_SIZE; i++) begin : g_lane
      lif_neuron #(
         .WEIGHT_WIDTH (WEIGHT_WIDTH),
         .MEM_WIDTH    (MEM_WIDTH),
         .THRESHOLD    (THRESHOLD),
         .BETA_SHIFT   (BETA_SHIFT)
      ) u_lif (
         .clk    (clk),
         .rst    (rst),
         .add_en (add_q),
         .weight (w_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
         .fire   (fire),
         .clear  (clear),
         .spike  (lane_spk[i])
      );
   end

   assign w_en          = w_en_q;
   assign w_addr        = w_addr_q;
   assign out_valid     = out_valid_q;
   assign out_spk       = out_spk_q;
   assign out_neuron    = out_neuron_q;
   assign out_time_step = out_step_q;
   assign layer_done    = layer_done_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_fc_lif_ec.sv
// Directed bench for fc_lif_ec: emits are scored against a queue of
// hand-computed results; lane state is spot-checked after key steps.
module tb_fc_lif_ec;
   import fc_pkg::*;

   localparam int NW = 7;
   localparam int SW = 6;
   localparam int AW = 11;
   localparam int XW = 1 + 4 + NW + SW;

   logic          clk = 1'b0;
   logic          rst;
   logic          en_accum;
   logic [8:0]    spk_addr;
   logic [NW-1:0] neuron;
   logic          new_spk_train_ready;
   logic          last_time_step;
   logic          w_en, w_en8;
   logic [AW-1:0] w_addr, w_addr8;
   logic [31:0]   w_data = '0;
   logic [31:0]   w_data8 = '0;
   logic          out_valid, out_valid8;
   logic [3:0]    out_spk, out_spk8;
   logic [NW-1:0] out_neuron, out_neuron8;
   logic [SW-1:0] out_time_step, out_time_step8;
   logic          layer_done, layer_done8;
   fc_state_e     dbg_state, dbg_state8;

   logic [31:0]   wmem [0:1919];
   logic [XW-1:0] exp_q[$];
   logic [XW-1:0] e_rec, g_rec;
   int            n_vec = 0;
   int            n_miss = 0;
   int            n_ld = 0;

   always #5 clk = ~clk;

   fc_lif_ec dut (
      .clk(clk), .rst(rst), .en_accum(en_accum), .spk_addr(spk_addr), .neuron(neuron),
      .new_spk_train_ready(new_spk_train_ready), .last_time_step(last_time_step),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
      .out_spk(out_spk), .out_neuron(out_neuron), .out_time_step(out_time_step),
      .layer_done(layer_done), .dbg_state(dbg_state)
   );

   fc_lif_ec #(.MEM_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .en_accum(en_accum), .spk_addr(spk_addr), .neuron(neuron),
      .new_spk_train_ready(new_spk_train_ready), .last_time_step(last_time_step),
      .w_en(w_en8), .w_addr(w_addr8), .w_data(w_data8), .out_valid(out_valid8),
      .out_spk(out_spk8), .out_neuron(out_neuron8), .out_time_step(out_time_step8),
      .layer_done(layer_done8), .dbg_state(dbg_state8)
   );

   // Weight BRAM models: one-cycle read latency.
   always @(posedge clk) begin
      if (w_en)  w_data  <= wmem[w_addr];
      if (w_en8) w_data8 <= wmem[w_addr8];
   end

   // Monitor: every out_valid pops one expected emit.
   always @(negedge clk) begin
      if (!rst && layer_done && !out_valid) begin
         n_vec++;
         n_miss++;
         $display("FAIL layer_done_alone got layer_done=1 out_valid=0 required out_valid=1");
      end
      if (out_valid) begin
         n_vec++;
         if (layer_done) n_ld++;
         g_rec = {layer_done, out_spk, out_neuron, out_time_step};
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_emit got ld=%0d spk=%b n=%0d t=%0d required none",
                     layer_done, out_spk, out_neuron, out_time_step);
         end else begin
            e_rec = exp_q.pop_front();
            if (g_rec !== e_rec) begin
               n_miss++;
               $display("FAIL emit got ld=%0d spk=%b n=%0d t=%0d required ld=%0d spk=%b n=%0d t=%0d",
                        g_rec[XW-1], g_rec[XW-2 -: 4], g_rec[SW +: NW], g_rec[SW-1:0],
                        e_rec[XW-1], e_rec[XW-2 -: 4], e_rec[SW +: NW], e_rec[SW-1:0]);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s got %0d required %0d", name, got, want);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) cyc();
   endtask

   task automatic push_exp(input logic ld, input logic [3:0] spk, input int nrn, input int stp);
      exp_q.push_back({ld, spk, NW'(nrn), SW'(stp)});
   endtask

   task automatic spike(input int addr);
      en_accum = 1'b1;
      spk_addr = 9'(addr);
      cyc();
      en_accum = 1'b0;
   endtask

   task automatic trig(input logic last);
      new_spk_train_ready = 1'b1;
      last_time_step      = last;
      cyc();
      new_spk_train_ready = 1'b0;
      last_time_step      = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1920; i++) wmem[i] = '0;
      rst = 1'b1;
      en_accum = 1'b0;
      spk_addr = '0;
      neuron = '0;
      new_spk_train_ready = 1'b0;
      last_time_step = 1'b0;
      wait_cyc(3);

      // Reset state
      @(negedge clk);
      check("rst_w_en", int'(w_en), 0);
      check("rst_w_addr", int'(w_addr), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_spk", int'(out_spk), 0);
      check("rst_out_neuron", int'(out_neuron), 0);
      check("rst_out_time_step", int'(out_time_step), 0);
      check("rst_layer_done", int'(layer_done), 0);
      check("rst_state", int'(dbg_state), int'(ST_IDLE));
      rst = 1'b0;

      // Single spike and trigger in the same cycle
      wmem[5] = {8'd70, 8'd30, 8'd20, 8'd10};
      cyc();
      neuron = '0;
      en_accum = 1'b1;
      spk_addr = 9'd5;
      new_spk_train_ready = 1'b1;
      push_exp(1'b0, 4'b1000, 0, 0);
      cyc();
      en_accum = 1'b0;
      new_spk_train_ready = 1'b0;
      @(negedge clk);
      check("t1_w_en", int'(w_en), 1);
      check("t1_w_addr", int'(w_addr), 5);
      wait_cyc(6);
      check("t1_mem_lane3", int'(dut.g_lane[3].u_lif.mem_q), 6);
      check("t1_mem_lane0", int'(dut.g_lane[0].u_lif.mem_q), 10);
      check("t1_mem_lane2", int'(dut.g_lane[2].u_lif.mem_q), 30);
      check("t1_acc_lane3", int'(dut.g_lane[3].u_lif.acc_q), 0);

      // Three back-to-back spikes of 25 on lane 0
      do_reset();
      wmem[7] = 32'h0000_0019;
      spike(7);
      spike(7);
      spike(7);
      push_exp(1'b0, 4'b0001, 0, 0);
      trig(1'b0);
      cyc();
      @(negedge clk);
      check("t2_acc_lane0", int'(dut.g_lane[0].u_lif.acc_q), 75);
      wait_cyc(6);
      check("t2_mem_lane0", int'(dut.g_lane[0].u_lif.mem_q), 11);

      // Leak-only steps, and a repeated trigger while busy
      do_reset();
      wmem[11] = 32'd40;
      spike(11);
      push_exp(1'b0, 4'b0000, 0, 0);
      trig(1'b0);
      wait_cyc(6);
      check("t3_mem_40", int'(dut.g_lane[0].u_lif.mem_q), 40);
      push_exp(1'b0, 4'b0000, 0, 1);
      new_spk_train_ready = 1'b1;
      wait_cyc(2);
      new_spk_train_ready = 1'b0;
      wait_cyc(8);
      check("t3_mem_35", int'(dut.g_lane[0].u_lif.mem_q), 35);
      push_exp(1'b0, 4'b0000, 0, 2);
      trig(1'b0);
      wait_cyc(6);
      check("t3_mem_31", int'(dut.g_lane[0].u_lif.mem_q), 31);

      // Saturation: ten 127 weights, 16-bit and 8-bit membranes
      do_reset();
      wmem[9] = 32'h7f7f_7f7f;
      for (int i = 0; i < 10; i++) spike(9);
      wait_cyc(3);
      @(negedge clk);
      check("t4_acc16", int'(dut.g_lane[0].u_lif.acc_q), 1270);
      check("t4_acc8_lane0", int'(dut8.g_lane[0].u_lif.acc_q), 127);
      check("t4_acc8_lane3", int'(dut8.g_lane[3].u_lif.acc_q), 127);
      push_exp(1'b0, 4'b1111, 0, 0);
      trig(1'b0);
      wait_cyc(6);
      check("t4_mem16", int'(dut.g_lane[0].u_lif.mem_q), 1206);
      check("t4_mem8", int'(dut8.g_lane[0].u_lif.mem_q), 63);
      check("t4_spk8", int'(out_spk8), 15);

      // Reset while a weight and a fire trigger are in flight
      do_reset();
      wmem[13] = 32'd50;
      en_accum = 1'b1;
      spk_addr = 9'd13;
      new_spk_train_ready = 1'b1;
      cyc();
      en_accum = 1'b0;
      new_spk_train_ready = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("t5_w_en", int'(w_en), 0);
      check("t5_w_addr", int'(w_addr), 0);
      check("t5_out_valid", int'(out_valid), 0);
      check("t5_state", int'(dbg_state), int'(ST_IDLE));
      check("t5_acc", int'(dut.g_lane[0].u_lif.acc_q), 0);
      wait_cyc(10);
      check("t5_mem", int'(dut.g_lane[0].u_lif.mem_q), 0);

      // Full layer: 8 groups x 10 steps, one weight of 64 per step
      do_reset();
      for (int g = 0; g < 8; g++)
         for (int l = 0; l < 4; l++)
            wmem[g*240 + l] = 32'd64 << (8*l);
      n_ld = 0;
      for (int g = 0; g < 8; g++) begin
         neuron = NW'(g*4);
         for (int s = 0; s < 10; s++) begin
            spike(s % 4);
            push_exp(g == 7 && s == 9, 4'(1 << (s % 4)), g*4, s);
            trig(s == 9);
            wait_cyc(6);
         end
      end
      check("t6_layer_done_count", n_ld, 1);
      check("t6_mem_lane1", int'(dut.g_lane[1].u_lif.mem_q), 0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
      check("pending_emits", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
